// File: rtl/one_hot_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : one_hot_pkg                                                     |
// | Purpose  : Shared definitions for the one-hot decode path: default         |
// |            widths, the decoded-result record for the default geometry and  |
// |            width-generic popcount / lowest-set-bit helpers.                |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package one_hot_pkg;

  localparam int c_DEFAULT_INPUT_WIDTH  = 16;
  localparam int c_DEFAULT_OUTPUT_WIDTH = $clog2(c_DEFAULT_INPUT_WIDTH);

  // Helpers accept any code up to this width; callers pass the live width.
  localparam int c_MAX_WIDTH = 64;

  // Decoded result for the default 16-bit geometry. The top level declares
  // an equivalent record sized from its own parameters.
  typedef struct packed {
    logic                              err;
    logic [c_DEFAULT_OUTPUT_WIDTH-1:0] idx;
  } decode_t;

  // Number of set bits among the lowest 'width' bits of vec.
  function automatic int popcount(input logic [c_MAX_WIDTH-1:0] vec,
                                  input int                     width);
    int n;
    n = 0;
    for (int i = 0; i < c_MAX_WIDTH; i++) begin
      if ((i < width) && vec[i]) n++;
    end
    return n;
  endfunction

  // Index of the lowest set bit among the lowest 'width' bits; 0 when none.
  function automatic int lowest_set_bit(input logic [c_MAX_WIDTH-1:0] vec,
                                        input int                     width);
    int idx;
    idx = 0;
    for (int i = c_MAX_WIDTH - 1; i >= 0; i--) begin
      if ((i < width) && vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage : one_hot_pkg
`default_nettype wire

// File: rtl/one_hot_decoder_index.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : one_hot_index                                                   |
// | Purpose  : Combinational one-hot analysis: index of the lowest set bit,    |
// |            zero-hot flag and multi-hot flag.                               |
// | Ports    : code  - one-hot code (INPUT_WIDTH)                              |
// |            idx   - index of lowest set bit, 0 when code is zero            |
// |            zero  - no bit set                                              |
// |            multi - two or more bits set                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module one_hot_index
  import one_hot_pkg::*;
#(
  parameter int INPUT_WIDTH  = c_DEFAULT_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0]  code,
  output logic [OUTPUT_WIDTH-1:0] idx,
  output logic                    zero,
  output logic                    multi
);

  // The code is padded to a power of two and reduced by a binary tree kept
  // in heap order: node k has children 2k+1 (lower bits) and 2k+2 (upper
  // bits); leaves occupy nodes c_LEAVES-1 .. c_NODES-1.
  localparam int c_LEAVES = 2 ** OUTPUT_WIDTH;
  localparam int c_NODES  = 2 * c_LEAVES - 1;

  logic [c_NODES-1:0]                   w_vld;
  logic [c_NODES-1:0][OUTPUT_WIDTH-1:0] w_idx;

  for (genvar j = 0; j < c_LEAVES; j++) begin : g_leaf
    if (j < INPUT_WIDTH) begin : g_real
      assign w_vld[c_LEAVES-1+j] = code[j];
    end else begin : g_pad
      assign w_vld[c_LEAVES-1+j] = 1'b0;
    end
    assign w_idx[c_LEAVES-1+j] = OUTPUT_WIDTH'(j);
  end

  // The lower-half child wins whenever it holds a set bit, so the root
  // carries the index of the lowest set bit after log2 mux levels.
  for (genvar k = 0; k < c_LEAVES - 1; k++) begin : g_node
    assign w_vld[k] = w_vld[2*k+1] | w_vld[2*k+2];
    assign w_idx[k] = w_vld[2*k+1] ? w_idx[2*k+1] : w_idx[2*k+2];
  end

  // With no bit set the tree would point at the top leaf; force 0 instead.
  assign idx   = w_vld[0] ? w_idx[0] : '0;
  assign zero  = ~w_vld[0];
  // Clearing the lowest set bit leaves something only if another bit was set.
  assign multi = |(code & (code - INPUT_WIDTH'(1)));

endmodule : one_hot_index
`default_nettype wire

// File: rtl/one_hot_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : one_hot_decoder                                                 |
// | Purpose  : Registered one-hot -> binary index decoder with valid/ready     |
// |            flow control, malformed-code flagging and a saturating count   |
// |            of malformed codes.                                             |
// | Ports    : clk_i, rst_ni (async, active-low)                               |
// |            code_i / valid_i / ready_o   - input stream                     |
// |            value_o / error_o / valid_o / ready_i - output stream           |
// |            clr_cnt_i / err_cnt_o        - malformed-code counter           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module one_hot_decoder
  import one_hot_pkg::*;
#(
  parameter int INPUT_WIDTH  = c_DEFAULT_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH),
  parameter int DROP_INVALID = 0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [INPUT_WIDTH-1:0]  code_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [OUTPUT_WIDTH-1:0] value_o,
  output logic                    error_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  input  logic                    clr_cnt_i,
  output logic [CNT_WIDTH-1:0]    err_cnt_o
);

  typedef struct packed {
    logic                    err;
    logic [OUTPUT_WIDTH-1:0] idx;
  } result_t;

  localparam bit                   c_DROP    = (DROP_INVALID != 0);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  logic [OUTPUT_WIDTH-1:0] w_idx;
  logic                    w_zero;
  logic                    w_multi;
  result_t                 w_dec;
  logic                    w_in_hs;
  logic                    w_out_hs;
  logic                    w_load;
  logic [CNT_WIDTH-1:0]    w_cnt_base;
  logic [CNT_WIDTH-1:0]    w_cnt_next;

  result_t                 r_out;
  logic                    r_valid;
  logic [CNT_WIDTH-1:0]    r_cnt;

  one_hot_index #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_index (
    .code  (code_i),
    .idx   (w_idx),
    .zero  (w_zero),
    .multi (w_multi)
  );

  assign w_dec.err = w_zero | w_multi;
  assign w_dec.idx = w_idx;

  // Single output register: it can take a new code whenever it is empty or
  // being drained this cycle, which gives one code per cycle with no bubble.
  assign ready_o  = ~r_valid | ready_i;
  assign w_in_hs  = valid_i & ready_o;
  assign w_out_hs = r_valid & ready_i;

  // In drop mode a malformed code is still consumed (and counted) but never
  // reaches the output register.
  assign w_load = w_in_hs & ~(c_DROP & w_dec.err);

  // Clear takes effect first so a malformed code accepted alongside it
  // leaves the count at 1.
  always_comb begin
    w_cnt_base = clr_cnt_i ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_in_hs && w_dec.err && (w_cnt_base != c_CNT_MAX)) begin
      w_cnt_next = w_cnt_base + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_load) begin
        r_out   <= w_dec;
        r_valid <= 1'b1;
      end else if (w_out_hs) begin
        // Data fields keep their last value once drained.
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o   = r_valid;
  assign value_o   = r_out.idx;
  assign error_o   = r_out.err;
  assign err_cnt_o = r_cnt;

endmodule : one_hot_decoder
`default_nettype wire
